// File: rtl/alu_mc.sv
// Registered ALU: single-cycle ops complete one cycle after acceptance;
// MUL/DIVU iterate one bit per cycle behind a start/busy/done handshake.
module alu_mc #(
  parameter int W     = 8,
  parameter int CMD_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CMD_W-1:0] alu_cmd,
  input  logic [W-1:0]     inA,
  input  logic [W-1:0]     inB,
  output logic [W-1:0]     rslt,
  output logic [W-1:0]     rslt_hi,
  output logic             carry,
  output logic             zero,
  output logic             doBranch,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(W);

  localparam logic [CMD_W-1:0] OP_ADD  = CMD_W'(5'b01000);
  localparam logic [CMD_W-1:0] OP_SUB  = CMD_W'(5'b01001);
  localparam logic [CMD_W-1:0] OP_AND  = CMD_W'(5'b01010);
  localparam logic [CMD_W-1:0] OP_OR   = CMD_W'(5'b01011);
  localparam logic [CMD_W-1:0] OP_SHL  = CMD_W'(5'b01100);
  localparam logic [CMD_W-1:0] OP_SHR  = CMD_W'(5'b01101);
  localparam logic [CMD_W-1:0] OP_MOV  = CMD_W'(5'b00100);
  localparam logic [CMD_W-1:0] OP_SLT  = CMD_W'(5'b00101);
  localparam logic [CMD_W-1:0] OP_BEQ  = CMD_W'(5'b00011);
  localparam logic [CMD_W-1:0] OP_PAR  = CMD_W'(5'b01111);
  localparam logic [CMD_W-1:0] OP_ROTL = CMD_W'(5'b11110);
  localparam logic [CMD_W-1:0] OP_XOR  = CMD_W'(5'b10100);
  localparam logic [CMD_W-1:0] OP_MUL  = CMD_W'(5'b10010);
  localparam logic [CMD_W-1:0] OP_DIVU = CMD_W'(5'b10011);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic [W-1:0] lo;
    logic         c;
    logic         br;
  } res_t;

  function automatic res_t eval_single(input logic [CMD_W-1:0] cmd,
                                       input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    res_t           r;
    logic [W:0]     s;
    logic [CNT_W-1:0] amt;
    r   = '0;
    s   = {1'b0, a} + {1'b0, b};
    amt = b[CNT_W-1:0];
    case (cmd)
      OP_ADD:  begin r.lo = s[W-1:0]; r.c = s[W]; end
      OP_SUB:  begin r.lo = a - b; r.c = (a < b); end
      OP_AND:  r.lo = a & b;
      OP_OR:   r.lo = a | b;
      OP_XOR:  r.lo = a ^ b;
      OP_SHL:  r.lo = a << b;
      OP_SHR:  r.lo = a >> b;
      OP_MOV:  r.lo = b;
      OP_SLT:  r.lo = {{(W-1){1'b0}}, (a < b)};
      OP_PAR:  r.lo = {{(W-1){1'b0}}, ^a};
      OP_ROTL: r.lo = (a << amt) | (a >> (W - int'(amt)));
      OP_BEQ:  r.br = (a == b);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Shift-add: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole {hi,lo} pair right.
  function automatic logic [2*W-1:0] mul_step(input logic [W-1:0] acc,
                                              input logic [W-1:0] mq,
                                              input logic [W-1:0] b);
    logic [W:0] s;
    s = mq[0] ? ({1'b0, acc} + {1'b0, b}) : {1'b0, acc};
    return {s, mq[W-1:1]};
  endfunction

  // Restoring division; a zero divisor naturally yields all-ones quotient
  // and the dividend as remainder.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                              input logic [W-1:0] q,
                                              input logic [W-1:0] b);
    logic [W:0] tmp;
    logic       qb;
    tmp = {rem, q[W-1]};
    qb  = 1'b0;
    if (tmp >= {1'b0, b}) begin
      tmp = tmp - {1'b0, b};
      qb  = 1'b1;
    end
    return {tmp[W-1:0], q[W-2:0], qb};
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt_p0;
  logic [W-1:0]     acc_p0;
  logic [W-1:0]     mq_p0;
  logic [W-1:0]     opb_p0;
  logic             div_p0;
  logic [2*W-1:0]   step_p1;
  res_t             single_p1;
  logic             is_multi;

  always_comb begin
    step_p1   = div_p0 ? div_step(acc_p0, mq_p0, opb_p0)
                       : mul_step(acc_p0, mq_p0, opb_p0);
    single_p1 = eval_single(alu_cmd, inA, inB);
    is_multi  = (alu_cmd == OP_MUL) || (alu_cmd == OP_DIVU);
  end

  assign busy = (state == S_RUN);

  // Acceptance / iteration stage: operands latched, results registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt_p0   <= '0;
      acc_p0   <= '0;
      mq_p0    <= '0;
      opb_p0   <= '0;
      div_p0   <= 1'b0;
      rslt     <= '0;
      rslt_hi  <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      doBranch <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_RUN: begin
          acc_p0 <= step_p1[2*W-1:W];
          mq_p0  <= step_p1[W-1:0];
          if (cnt_p0 == '0) begin
            state    <= S_DONE;
            done     <= 1'b1;
            rslt     <= step_p1[W-1:0];
            rslt_hi  <= step_p1[2*W-1:W];
            carry    <= 1'b0;
            zero     <= (step_p1[W-1:0] == '0);
            doBranch <= 1'b0;
          end else begin
            cnt_p0 <= cnt_p0 - CNT_W'(1);
          end
        end
        default: begin
          if (start) begin
            if (is_multi) begin
              state  <= S_RUN;
              cnt_p0 <= CNT_W'(W - 1);
              acc_p0 <= '0;
              mq_p0  <= inA;
              opb_p0 <= inB;
              div_p0 <= (alu_cmd == OP_DIVU);
            end else begin
              state    <= S_DONE;
              done     <= 1'b1;
              rslt     <= single_p1.lo;
              rslt_hi  <= '0;
              carry    <= single_p1.c;
              zero     <= (single_p1.lo == '0);
              doBranch <= single_p1.br;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed/random bench for alu_mc with a queue-based scoreboard.
module tb_alu_mc;
  localparam int W = 8;

  localparam logic [4:0] OP_ADD  = 5'b01000;
  localparam logic [4:0] OP_SUB  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_SHL  = 5'b01100;
  localparam logic [4:0] OP_SHR  = 5'b01101;
  localparam logic [4:0] OP_MOV  = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b00101;
  localparam logic [4:0] OP_BEQ  = 5'b00011;
  localparam logic [4:0] OP_PAR  = 5'b01111;
  localparam logic [4:0] OP_ROTL = 5'b11110;
  localparam logic [4:0] OP_XOR  = 5'b10100;
  localparam logic [4:0] OP_MUL  = 5'b10010;
  localparam logic [4:0] OP_DIVU = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_BAD  = 5'b11111;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [4:0] alu_cmd;
  logic [7:0] inA, inB, rslt, rslt_hi;
  logic       carry, zero, doBranch, busy, done;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       c;
    logic       z;
    logic       br;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_mc #(.W(W), .CMD_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_cmd(alu_cmd),
    .inA(inA), .inB(inB), .rslt(rslt), .rslt_hi(rslt_hi),
    .carry(carry), .zero(zero), .doBranch(doBranch),
    .busy(busy), .done(done)
  );

  function automatic exp_t model(input logic [4:0] cmd, input logic [7:0] a,
                                 input logic [7:0] b);
    exp_t        e;
    int          k;
    logic [15:0] p;
    logic [8:0]  s;
    e = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    case (cmd)
      OP_ADD:  begin s = a + b; e.lo = s[7:0]; e.c = s[8]; end
      OP_SUB:  begin e.lo = 8'((int'(a) - int'(b) + 256) % 256); e.c = (int'(a) < int'(b)); end
      OP_AND:  e.lo = a & b;
      OP_OR:   e.lo = a | b;
      OP_XOR:  e.lo = a ^ b;
      OP_SHL:  e.lo = (b >= 8) ? 8'h00 : 8'((16'(a) << b) & 16'hff);
      OP_SHR:  e.lo = (b >= 8) ? 8'h00 : 8'(a >> b);
      OP_MOV:  e.lo = b;
      OP_SLT:  e.lo = (a < b) ? 8'd1 : 8'd0;
      OP_PAR:  e.lo = 8'(a[0] ^ a[1] ^ a[2] ^ a[3] ^ a[4] ^ a[5] ^ a[6] ^ a[7]);
      OP_ROTL: begin
        k = int'(b) % 8;
        p = {a, a} << k;
        e.lo = p[15:8];
      end
      OP_BEQ:  e.br = (a == b);
      OP_MUL:  begin p = 16'(a) * 16'(b); e.lo = p[7:0]; e.hi = p[15:8]; end
      OP_DIVU: begin
        if (b == 0) begin e.lo = 8'hff; e.hi = a; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      default: ;
    endcase
    e.z = (e.lo == 8'h00);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] cmd, input logic [7:0] a, input logic [7:0] b);
    start   = 1'b1;
    alu_cmd = cmd;
    inA     = a;
    inB     = b;
    sb.push_back(model(cmd, a, b));
    tick();
    start = 1'b0;
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, ".rslt"},     rslt,     e.lo);
      check({tag, ".rslt_hi"},  rslt_hi,  e.hi);
      check({tag, ".carry"},    carry,    e.c);
      check({tag, ".zero"},     zero,     e.z);
      check({tag, ".doBranch"}, doBranch, e.br);
    end
  endtask

  task automatic wait_done(input string tag, input int budget, input int exp_lat);
    int lat;
    lat = 0;
    while (done !== 1'b1 && lat < budget) begin
      tick();
      lat++;
    end
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".latency"}, lat, exp_lat);
    compare(tag);
  endtask

  logic [4:0] ops [16];
  logic [4:0] op;
  logic [7:0] ra, rb;

  initial begin
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_MOV, OP_SLT,
            OP_BEQ, OP_PAR, OP_ROTL, OP_XOR, OP_MUL, OP_DIVU, OP_NOP, OP_BAD};
    reset = 1'b1; start = 1'b0; alu_cmd = '0; inA = '0; inB = '0;
    tick();
    tick();
    check("rst.rslt", rslt, 0);
    check("rst.rslt_hi", rslt_hi, 0);
    check("rst.flags", {carry, zero, doBranch, busy, done}, 0);
    reset = 1'b0;
    tick();
    check("idle.done", done, 0);

    issue(OP_ADD, 8'd200, 8'd100);
    check("add.busy", busy, 0);
    wait_done("add", 0, 0);
    issue(OP_SUB, 8'd3, 8'd5);
    wait_done("sub", 0, 0);
    issue(OP_SUB, 8'd9, 8'd9);
    wait_done("sub_eq", 0, 0);

    // MUL with an ignored start in the middle of the run
    issue(OP_MUL, 8'd255, 8'd255);
    for (int i = 1; i <= W; i++) begin
      check("mul.busy", busy, 1);
      check("mul.no_done", done, 0);
      if (i == 3) begin
        start = 1'b1; alu_cmd = OP_ADD; inA = 8'd1; inB = 8'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("mul.busy_end", busy, 0);
    wait_done("mul", 0, 0);
    tick();
    check("mul.single_done", done, 0);
    check("mul.hold", rslt, 8'h01);

    issue(OP_DIVU, 8'd200, 8'd7);
    wait_done("divu", W + 2, W);
    issue(OP_DIVU, 8'd5, 8'd0);
    wait_done("divu0", W + 2, W);
    issue(OP_ROTL, 8'h81, 8'd9);
    wait_done("rotl", 0, 0);
    issue(OP_SHL, 8'h01, 8'd8);
    wait_done("shl8", 0, 0);
    issue(OP_SLT, 8'd3, 8'd5);
    wait_done("slt", 0, 0);
    issue(OP_PAR, 8'h07, 8'd0);
    wait_done("par", 0, 0);
    issue(OP_BEQ, 8'd5, 8'd5);
    wait_done("beq", 0, 0);
    issue(OP_ADD, 8'd1, 8'd1);
    wait_done("b2b_add", 0, 0);

    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 15)];
      ra = 8'($urandom_range(0, 255));
      rb = (n % 3 == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
      issue(op, ra, rb);
      wait_done("rand", W + 2, (op == OP_MUL || op == OP_DIVU) ? W : 0);
    end

    // Reset in the middle of a MUL aborts it
    tick();
    issue(OP_MUL, 8'd15, 8'd15);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.rslt", rslt, 0);
    check("abort.rslt_hi", rslt_hi, 0);
    issue(OP_MUL, 8'd2, 8'd3);
    wait_done("mul_after_rst", W + 2, W);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
